stopwatch_ctrl: RTL

//   Sequencing controller for the 4-digit BCD stopwatch datapath (00.00-99.99 s).

---
 rtl/stopwatch_pkg.sv | 17 +
 rtl/btn_debounce.sv | 50 +++++
 rtl/stopwatch_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller and the BCD timer core.
//   BCD_W   : width of the 4-digit BCD word {tens_s, s, tenths, hundredths}
//   BCD_MAX : saturation value 99.99 s
//   state_t : controller state encoding
package stopwatch_pkg;

  localparam int BCD_W = 16;
  localparam logic [BCD_W-1:0] BCD_MAX = 16'h9999;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser followed by a stability
// counter. The accepted level only changes after DEB_CYCLES consecutive
// synchronised samples that differ from it. press is a single-cycle pulse on
// the accepted 0->1 edge; releases produce nothing.
// Ports:
//   clk     in  system clock
//   rst     in  asynchronous reset, active-high
//   btn_raw in  raw asynchronous button level
//   press   out one-cycle press event
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync_1;
  logic          sync_2;
  logic          level;
  logic [CW-1:0] stable_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      level      <= 1'b0;
      stable_cnt <= '0;
      press      <= 1'b0;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
      press  <= 1'b0;
      // Any sample agreeing with the accepted level restarts the run.
      if (sync_2 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CW'(DEB_CYCLES - 1)) begin
        level      <= sync_2;
        stable_cnt <= '0;
        press      <= sync_2;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Sequencing controller for the 4-digit BCD stopwatch (00.00-99.99 s).
// Debounces the two buttons into press events, drives single-cycle
// start/stop/clear commands to the timer core, produces the 100 Hz count
// enable and selects the displayed value (live count or frozen lap).
// Build option: define STOPWATCH_LAP_EN to implement the lap feature
// (LAP state, lap register, lap_active). Without it, lap/reset in RUN is
// ignored, lap_active is 0 and disp_val always follows timer_val.
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   btn_ss       raw start/stop button
//   btn_lr       raw lap/reset button
//   timer_val    BCD count from the timer core
//   tick_100hz   one-cycle count enable every TICK_DIV cycles
//   timer_start  one-cycle start command
//   timer_stop   one-cycle stop command
//   timer_rst    one-cycle clear command
//   disp_val     BCD value for the display scanner
//   running      high in RUN or LAP
//   lap_active   high in LAP
//
// state | meaning
// IDLE  | cleared, waiting for start
// RUN   | timer counting, display live
// LAP   | timer counting, display frozen at lap_reg
// PAUSE | timer halted, value held
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_DIV   = CLK_HZ / 100,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_ss,
  input  logic             btn_lr,
  input  logic [BCD_W-1:0] timer_val,
  output logic             tick_100hz,
  output logic             timer_start,
  output logic             timer_stop,
  output logic             timer_rst,
  output logic [BCD_W-1:0] disp_val,
  output logic             running,
  output logic             lap_active
);

  localparam int TICK_W = $clog2(TICK_DIV + 1);

  logic ss_press;
  logic lr_press;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_ss),
    .press   (ss_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lr (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_lr),
    .press   (lr_press)
  );

  // Tick divider, free-running in every state.
  logic [TICK_W-1:0] tick_cnt;

  assign tick_100hz = (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick_100hz) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // FSM
  state_t state;
  state_t state_nxt;
  logic   start_nxt;
  logic   stop_nxt;
  logic   clr_nxt;
  logic   lap_load;
  logic   at_max;

  assign at_max = (timer_val == BCD_MAX);

  // Start/stop wins over lap/reset, and saturation wins over a lap press,
  // so each branch issues at most one command.
  always_comb begin
    state_nxt = state;
    start_nxt = 1'b0;
    stop_nxt  = 1'b0;
    clr_nxt   = 1'b0;
    lap_load  = 1'b0;
    case (state)
      IDLE: begin
        if (ss_press) begin
          start_nxt = 1'b1;
          state_nxt = RUN;
        end else if (lr_press) begin
          clr_nxt = 1'b1;
        end
      end
      RUN: begin
        if (ss_press || at_max) begin
          stop_nxt  = 1'b1;
          state_nxt = PAUSE;
        end
`ifdef STOPWATCH_LAP_EN
        else if (lr_press) begin
          lap_load  = 1'b1;
          state_nxt = LAP;
        end
`endif
      end
`ifdef STOPWATCH_LAP_EN
      LAP: begin
        if (ss_press || at_max) begin
          stop_nxt  = 1'b1;
          state_nxt = PAUSE;
        end else if (lr_press) begin
          state_nxt = RUN;
        end
      end
`endif
      PAUSE: begin
        // A start press at saturation is consumed without effect.
        if (ss_press) begin
          if (!at_max) begin
            start_nxt = 1'b1;
            state_nxt = RUN;
          end
        end else if (lr_press) begin
          clr_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      timer_start <= 1'b0;
      timer_stop  <= 1'b0;
      timer_rst   <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer_start <= start_nxt;
      timer_stop  <= stop_nxt;
      timer_rst   <= clr_nxt;
    end
  end

  assign running = (state == RUN) || (state == LAP);

`ifdef STOPWATCH_LAP_EN
  logic [BCD_W-1:0] lap_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_reg <= '0;
    end else if (lap_load) begin
      lap_reg <= timer_val;
    end
  end

  assign lap_active = (state == LAP);
  assign disp_val   = (state == LAP) ? lap_reg : timer_val;
`else
  // lap_load only exists to feed the lap register.
  logic unused_lap;
  assign unused_lap = lap_load;
  assign lap_active = 1'b0;
  assign disp_val   = timer_val;
`endif

endmodule
